// File: rtl/ie_alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one execute-stage operand path and ALU
// among NUM_CORES requesters; returns each result with a one-cycle response pulse.
module ie_alu_arbiter #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned AW        = 11,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_CORES-1:0]    req,
   input  logic [NUM_CORES*32-1:0] req_rs1,
   input  logic [NUM_CORES*32-1:0] req_rs2,
   input  logic [NUM_CORES*AW-1:0] req_pc,
   input  logic [NUM_CORES-1:0]    req_sel,
   input  logic [NUM_CORES*4-1:0]  req_op,
   output logic [NUM_CORES-1:0]    grant,
   output logic [31:0]             exe_rs1_value,
   output logic [AW-1:0]           exe_inst_addr,
   output logic                    exe_sel,
   output logic                    exe_en,
   output logic [31:0]             exe_rs2_value,
   output logic [3:0]              exe_op,
   output logic                    alu_start,
   input  logic                    alu_done,
   input  logic [31:0]             alu_result,
   output logic [NUM_CORES-1:0]    resp_valid,
   output logic [31:0]             resp_data,
   output logic                    resp_err
);

   localparam int unsigned IW  = $clog2(NUM_CORES);
   localparam int unsigned CW  = $clog2(TIMEOUT);
   localparam int unsigned DW  = 32;
   localparam int unsigned OPW = 4;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

   state_e               state_q, state_d;
   logic [IW-1:0]        last_q, last_d, gidx_q, gidx_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NUM_CORES-1:0] grant_q, grant_d, resp_valid_q, resp_valid_d;
   logic [DW-1:0]        rs1_q, rs1_d, rs2_q, rs2_d, resp_data_q, resp_data_d;
   logic [AW-1:0]        pc_q, pc_d;
   logic [OPW-1:0]       op_q, op_d;
   logic                 sel_q, sel_d, en_q, en_d, start_q, start_d, err_q, err_d;

   logic                 pick_vld_c;
   logic [IW-1:0]        pick_idx_c;
   int unsigned          idx_c;
   logic [DW-1:0]        mux_rs1_c, mux_rs2_c;
   logic [AW-1:0]        mux_pc_c;
   logic [OPW-1:0]       mux_op_c;
   logic                 mux_sel_c;

   // First requester after the last granted index, wrapping around
   always_comb begin
      pick_vld_c = 1'b0;
      pick_idx_c = '0;
      idx_c      = 0;
      for (int unsigned k = 1; k <= NUM_CORES; k++) begin
         idx_c = 32'(last_q) + k;
         if (idx_c >= NUM_CORES) idx_c = idx_c - NUM_CORES;
         if (!pick_vld_c && req[IW'(idx_c)]) begin
            pick_vld_c = 1'b1;
            pick_idx_c = IW'(idx_c);
         end
      end
   end

   // Operand select for the winning core
   always_comb begin
      mux_rs1_c = '0;
      mux_rs2_c = '0;
      mux_pc_c  = '0;
      mux_op_c  = '0;
      mux_sel_c = 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (pick_idx_c == IW'(i)) begin
            mux_rs1_c = req_rs1[DW*i +: DW];
            mux_rs2_c = req_rs2[DW*i +: DW];
            mux_pc_c  = req_pc[AW*i +: AW];
            mux_op_c  = req_op[OPW*i +: OPW];
            mux_sel_c = req_sel[i];
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      gidx_d       = gidx_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      pc_d         = pc_q;
      op_d         = op_q;
      sel_d        = sel_q;
      resp_valid_d = '0;
      resp_data_d  = '0;
      err_d        = 1'b0;
      start_d      = 1'b0;
      en_d         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_vld_c) begin
               state_d             = S_ISSUE;
               gidx_d              = pick_idx_c;
               grant_d             = '0;
               grant_d[pick_idx_c] = 1'b1;
               rs1_d               = mux_rs1_c;
               rs2_d               = mux_rs2_c;
               pc_d                = mux_pc_c;
               op_d                = mux_op_c;
               sel_d               = mux_sel_c;
               start_d             = 1'b1;
               en_d                = 1'b1;
            end
         end
         S_ISSUE: begin
            cnt_d = '0;
            if (alu_done) begin
               state_d      = S_RESP;
               resp_valid_d = grant_q;
               resp_data_d  = alu_result;
            end else begin
               state_d = S_WAIT;
               en_d    = 1'b1;
            end
         end
         S_WAIT: begin
            if (alu_done) begin
               state_d      = S_RESP;
               resp_valid_d = grant_q;
               resp_data_d  = alu_result;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               // Abort: respond with zero data and the error flag
               state_d      = S_RESP;
               resp_valid_d = grant_q;
               err_d        = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               en_d  = 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            last_d  = gidx_q;
            grant_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_q       <= IW'(NUM_CORES - 1);
         gidx_q       <= '0;
         cnt_q        <= '0;
         grant_q      <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         pc_q         <= '0;
         op_q         <= '0;
         sel_q        <= 1'b0;
         en_q         <= 1'b0;
         start_q      <= 1'b0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         gidx_q       <= gidx_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         pc_q         <= pc_d;
         op_q         <= op_d;
         sel_q        <= sel_d;
         en_q         <= en_d;
         start_q      <= start_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         err_q        <= err_d;
      end
   end

   assign grant         = grant_q;
   assign exe_rs1_value = rs1_q;
   assign exe_rs2_value = rs2_q;
   assign exe_inst_addr = pc_q;
   assign exe_op        = op_q;
   assign exe_sel       = sel_q;
   assign exe_en        = en_q;
   assign alu_start     = start_q;
   assign resp_valid    = resp_valid_q;
   assign resp_data     = resp_data_q;
   assign resp_err      = err_q;

endmodule

// File: tb/tb_ie_alu_arbiter.sv
// Bench for ie_alu_arbiter: transaction-level model compared every cycle,
// a bench-side ALU with programmable latency, and directed literal checks.
module tb_ie_alu_arbiter;
   localparam int unsigned N  = 4;
   localparam int unsigned AW = 11;
   localparam int unsigned TO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req, req_sel, grant, resp_valid;
   logic [N*32-1:0] req_rs1, req_rs2;
   logic [N*AW-1:0] req_pc;
   logic [N*4-1:0]  req_op;
   logic [31:0]     exe_rs1_value, exe_rs2_value, resp_data;
   logic [31:0]     alu_result = '0;
   logic [AW-1:0]   exe_inst_addr;
   logic [3:0]      exe_op;
   logic            exe_sel, exe_en, alu_start, resp_err;
   logic            alu_done = 1'b0;

   ie_alu_arbiter #(.NUM_CORES(N), .AW(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_pc(req_pc), .req_sel(req_sel), .req_op(req_op), .grant(grant),
      .exe_rs1_value(exe_rs1_value), .exe_inst_addr(exe_inst_addr),
      .exe_sel(exe_sel), .exe_en(exe_en), .exe_rs2_value(exe_rs2_value),
      .exe_op(exe_op), .alu_start(alu_start), .alu_done(alu_done),
      .alu_result(alu_result), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         default: return a ^ b;
      endcase
   endfunction

   // Bench ALU: done alu_lat cycles after alu_start (0 = same cycle, -1 = never)
   int   alu_lat = 0;
   int   alu_cnt = -1;
   logic force_done = 1'b0;
   always @(negedge clk) begin
      if (rst) alu_cnt = -1;
      else if (alu_start) alu_cnt = 0;
      else if (alu_cnt >= 0) alu_cnt++;
      if (alu_lat >= 0 && alu_cnt == alu_lat) begin
         alu_done   = 1'b1;
         alu_result = alu_f(exe_op, exe_sel ? 32'(exe_inst_addr) : exe_rs1_value, exe_rs2_value);
         alu_cnt    = -1;
      end else begin
         alu_done   = force_done;
         alu_result = $urandom;
      end
   end

   // Transaction-level model: expected outputs after each rising edge
   logic [N-1:0]  e_grant, e_rv;
   logic [31:0]   e_rs1, e_rs2, e_data;
   logic [AW-1:0] e_pc;
   logic [3:0]    e_op;
   logic          e_sel, e_en, e_start, e_err;
   bit            m_init = 1'b0, m_busy = 1'b0, m_resp = 1'b0, found;
   int            m_owner = 0, m_last = N - 1, m_t = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_init = 1'b1; m_busy = 1'b0; m_resp = 1'b0; m_last = N - 1;
         e_grant = '0; e_rv = '0; e_rs1 = '0; e_rs2 = '0; e_data = '0; e_pc = '0;
         e_op = '0; e_sel = 1'b0; e_en = 1'b0; e_start = 1'b0; e_err = 1'b0;
      end else if (m_init) begin
         e_rv = '0; e_data = '0; e_err = 1'b0; e_start = 1'b0;
         if (m_resp) begin
            m_resp = 1'b0; m_busy = 1'b0; m_last = m_owner;
            e_grant = '0; e_en = 1'b0;
         end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
               if (!found && req[(m_last + k) % N]) begin
                  found = 1'b1;
                  m_owner = (m_last + k) % N;
               end
            end
            if (found) begin
               e_grant = '0; e_grant[m_owner] = 1'b1;
               e_rs1 = req_rs1[32*m_owner +: 32];
               e_rs2 = req_rs2[32*m_owner +: 32];
               e_pc  = req_pc[AW*m_owner +: AW];
               e_op  = req_op[4*m_owner +: 4];
               e_sel = req_sel[m_owner];
               e_start = 1'b1; e_en = 1'b1; m_busy = 1'b1; m_t = 0;
            end
         end else if (alu_done || m_t == TO) begin
            // Done wins over the timeout that lands on the same cycle
            e_rv = e_grant; e_data = alu_done ? alu_result : 32'h0; e_err = !alu_done;
            e_en = 1'b0; m_resp = 1'b1;
         end else begin
            m_t++; e_en = 1'b1;
         end
      end
   end

   logic prev_start = 1'b0;
   always @(negedge clk) begin
      if (m_init) begin
         chk("grant", grant, e_grant);
         chk("resp_valid", resp_valid, e_rv);
         if (e_rv != '0) begin
            chk("resp_data", resp_data, e_data);
            chk("resp_err", resp_err, e_err);
         end
         chk("alu_start", alu_start, e_start);
         chk("exe_en", exe_en, e_en);
         chk("exe_rs1_value", exe_rs1_value, e_rs1);
         chk("exe_rs2_value", exe_rs2_value, e_rs2);
         chk("exe_inst_addr", exe_inst_addr, e_pc);
         chk("exe_op", exe_op, e_op);
         chk("exe_sel", exe_sel, e_sel);
         chk("grant_onehot0", $onehot0(grant), 1);
         chk("resp_onehot0", $onehot0(resp_valid), 1);
         chk("start_not_back_to_back", prev_start & alu_start, 0);
         prev_start = alu_start;
      end
   end

   task automatic set_core(input int i, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [AW-1:0] pc, input logic sel, input logic [3:0] op);
      req_rs1[32*i +: 32] = rs1;
      req_rs2[32*i +: 32] = rs2;
      req_pc[AW*i +: AW]  = pc;
      req_sel[i]          = sel;
      req_op[4*i +: 4]    = op;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Cycles from request until resp_valid, bounded; returns budget on expiry
   task automatic run_to_resp(input int budget, input int drop_at, output int cyc, output int starts);
      cyc = 0; starts = 0;
      while (cyc < budget) begin
         tick(1); cyc++;
         if (alu_start) starts++;
         if (cyc == drop_at) req = '0;
         if (resp_valid != '0) break;
      end
   endtask

   logic [N-1:0] order [5];
   int cyc, starts;

   initial begin
      order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst = 1'b1; req = '0; req_sel = '0; req_rs1 = '0; req_rs2 = '0; req_pc = '0; req_op = '0;
      tick(3);
      chk("reset_grant", grant, 0);
      chk("reset_resp_valid", resp_valid, 0);
      chk("reset_alu_start", alu_start, 0);
      chk("reset_exe_en", exe_en, 0);
      chk("reset_resp_data", resp_data, 0);
      rst = 1'b0;
      tick(1);

      // Single request, combinational ALU
      set_core(2, 32'h10, 32'h5, '0, 1'b0, 4'd0);
      alu_lat = 0; req = 4'b0100;
      tick(1);
      chk("single_issue_grant", grant, 4'b0100);
      chk("single_issue_start", alu_start, 1);
      chk("single_issue_rs1", exe_rs1_value, 32'h10);
      tick(1);
      chk("single_resp_valid", resp_valid, 4'b0100);
      chk("single_resp_data", resp_data, 32'h15);
      chk("single_resp_err", resp_err, 0);
      req = '0;
      tick(1);

      // PC operand; later operand changes must be ignored
      set_core(1, 32'h1234, 32'h1, 11'h7FF, 1'b1, 4'd0);
      alu_lat = 3; req = 4'b0010;
      tick(1);
      chk("pc_issue_sel", exe_sel, 1);
      chk("pc_issue_addr", exe_inst_addr, 11'h7FF);
      chk("pc_issue_en", exe_en, 1);
      set_core(1, 32'hFFFF_FFFF, 32'h99, '0, 1'b0, 4'd2);
      tick(1);
      chk("pc_wait_en", exe_en, 1);
      chk("pc_wait_start", alu_start, 0);
      run_to_resp(40, 0, cyc, starts);
      chk("pc_resp_data", resp_data, 32'h800);
      req = '0;
      tick(1);

      // Fairness from reset with all cores requesting
      rst = 1'b1; tick(1); rst = 1'b0;
      for (int i = 0; i < N; i++) set_core(i, 32'(16*i + 1), 32'(i), AW'(i), 1'b0, 4'd0);
      alu_lat = 0; req = 4'hF;
      tick(1);
      chk("rr_grant_0", grant, order[0]);
      for (int k = 1; k < 5; k++) begin
         tick(3);
         chk($sformatf("rr_grant_%0d", k), grant, order[k]);
         chk($sformatf("rr_start_%0d", k), alu_start, 1);
      end
      tick(1); req = '0; tick(2);

      // Multicycle ALU; requester drops req mid-transaction
      set_core(0, 32'd100, 32'd23, '0, 1'b0, 4'd1);
      alu_lat = 5; req = 4'b0001;
      run_to_resp(40, 2, cyc, starts);
      chk("multi_latency", cyc, 7);
      chk("multi_start_count", starts, 1);
      chk("multi_resp_valid", resp_valid, 4'b0001);
      chk("multi_resp_data", resp_data, 32'd77);
      tick(1);

      // Timeout abort
      set_core(3, 32'h5, 32'h6, '0, 1'b0, 4'd0);
      alu_lat = -1; req = 4'b1000;
      run_to_resp(40, 0, cyc, starts);
      chk("timeout_latency", cyc, 18);
      chk("timeout_resp_valid", resp_valid, 4'b1000);
      chk("timeout_resp_err", resp_err, 1);
      chk("timeout_resp_data", resp_data, 0);
      req = '0; tick(1);

      // Next request after timeout is normal
      set_core(2, 32'h7, 32'h8, '0, 1'b0, 4'd2);
      alu_lat = 0; req = 4'b0100;
      tick(1);
      chk("post_to_grant", grant, 4'b0100);
      tick(1);
      chk("post_to_resp_err", resp_err, 0);
      chk("post_to_resp_data", resp_data, 32'hF);
      req = '0; tick(1);

      // Done on the timeout cycle wins
      set_core(1, 32'h40, 32'h2, '0, 1'b0, 4'd0);
      alu_lat = 16; req = 4'b0010;
      run_to_resp(40, 0, cyc, starts);
      chk("edge_latency", cyc, 18);
      chk("edge_resp_err", resp_err, 0);
      chk("edge_resp_data", resp_data, 32'h42);
      req = '0; tick(1);

      // Spurious done while idle is ignored
      force_done = 1'b1; tick(2); force_done = 1'b0; tick(1);
      chk("idle_done_resp", resp_valid, 0);
      chk("idle_done_grant", grant, 0);

      // Reset during WAIT
      set_core(3, 32'h3, 32'h3, '0, 1'b0, 4'd0);
      alu_lat = -1; req = 4'b1000;
      tick(4);
      chk("prerst_grant", grant, 4'b1000);
      rst = 1'b1; tick(1);
      chk("rst_mid_grant", grant, 0);
      chk("rst_mid_resp", resp_valid, 0);
      chk("rst_mid_en", exe_en, 0);
      rst = 1'b0;
      set_core(0, 32'h11, 32'h22, '0, 1'b0, 4'd0);
      alu_lat = 0; req = 4'b1001;
      tick(1);
      chk("postrst_grant", grant, 4'b0001);
      tick(1);
      chk("postrst_resp", resp_valid, 4'b0001);
      chk("postrst_data", resp_data, 32'h33);
      req = 4'b1000;
      tick(2);
      chk("postrst_grant3", grant, 4'b1000);
      tick(1);
      req = '0; tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/ie_alu_arbiter.md
Name: ie_alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one execute-stage operand path (IE operand-A mux, rs2 path, ALU) among NUM_CORES requesting cores.
- Latches the winning core's operands and drives the operand-A mux select/enable and ALU start.
- Waits for ALU completion, then returns the result to the granted core with a one-cycle response pulse.
- Sits between the per-core decode stages and the shared execute unit.

Parameters:
NUM_CORES, 4, number of requesters (2..8)
AW, 11, instruction-memory address width
TIMEOUT, 16, cycles after alu_start without alu_done before aborting with error (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  NUM_CORES  per-core request, held until own resp_valid
req_rs1  in  NUM_CORES*32  per-core rs1 value, core i at [32i+31:32i]
req_rs2  in  NUM_CORES*32  per-core rs2 value
req_pc  in  NUM_CORES*AW  per-core instruction address
req_sel  in  NUM_CORES  operand-A select per core: 0=rs1, 1=zero-extended pc
req_op  in  NUM_CORES*4  ALU opcode per core
grant  out  NUM_CORES  one-hot, core currently owning the execute path
exe_rs1_value  out  32  latched rs1 to operand-A mux
exe_inst_addr  out  AW  latched pc to operand-A mux
exe_sel  out  1  operand-A mux select
exe_en  out  1  operand-A mux enable
exe_rs2_value  out  32  latched rs2 to ALU
exe_op  out  4  latched opcode to ALU
alu_start  out  1  one-cycle start pulse to ALU
alu_done  in  1  ALU result valid
alu_result  in  32  ALU result
resp_valid  out  NUM_CORES  one-hot one-cycle response pulse
resp_data  out  32  result, valid with resp_valid
resp_err  out  1  high with resp_valid on timeout abort

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst, sampled on the rising clk edge.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer last = NUM_CORES-1, so core 0 has highest priority after reset.
  - Timeout counter 0.
- IDLE:
  - If req has any bit set, pick the first set bit scanning from last+1 upward with wrap.
  - Latch that core's rs1/rs2/pc/sel/op into the exe_* registers and set grant one-hot.
  - Go to ISSUE. With no request, stay in IDLE and hold grant 0.
- ISSUE (1 cycle):
  - alu_start=1 and exe_en=1; clear the counter.
  - If alu_done=1 in this cycle (combinational ALU), capture alu_result and go to RESP.
  - Otherwise go to WAIT.
- WAIT:
  - exe_en=1 and alu_start=0; counter increments each cycle.
  - alu_done=1: capture result and go to RESP.
  - Counter reaching TIMEOUT-1 without alu_done: set the error flag and go to RESP with resp_data=0.
  - alu_done on the same cycle as timeout: done wins, no error.
- RESP (1 cycle):
  - resp_valid = grant, resp_data = captured result, resp_err = error flag.
  - last = granted index; grant cleared; exe_en=0; go to IDLE.
- Min latency: req high in cycle 0 → ISSUE in cycle 1 → resp_valid in cycle 2 (done in ISSUE). Back-to-back issue every 3 cycles.
- Operands are latched only in IDLE. Requester changes to operands after grant are ignored.
- Granted core dropping req mid-transaction: transaction still completes and resp_valid still pulses.
- alu_done outside ISSUE/WAIT is ignored.
- exe_sel/exe_rs1_value/exe_inst_addr hold their last values while exe_en=0.
- Downstream mux forms {21'b0, exe_inst_addr} when exe_sel=1.
- A core whose req is held across its own RESP is eligible again, but at lowest priority.
- rst mid-transaction: abort immediately, no resp_valid, return to reset values.
- Invariants: at most one bit each of grant and resp_valid set; alu_start never asserted in two consecutive cycles.

Test Plan:
- Single request: core 2 req, sel=0, rs1=0x0000_0010, op=ADD; ALU returns 0x15 in ISSUE → resp_valid=4'b0100 in cycle 2, resp_data=0x15, resp_err=0.
- PC operand: core 1 sel=1, pc=11'h7FF → exe_sel=1, exe_inst_addr=0x7FF, exe_en=1 during ISSUE/WAIT.
- Fairness: all four reqs held continuously, ALU done in ISSUE → grant order 0,1,2,3,0, each 3 cycles apart, never two grants at once.
- Multicycle ALU: alu_done 5 cycles after alu_start → resp_valid exactly one cycle after alu_done, alu_start high only 1 cycle.
- Timeout: alu_done never asserted → resp_valid on the cycle after counter hits 15, resp_err=1, resp_data=0; next request serviced normally.
- Reset mid-WAIT: rst pulsed while core 3 granted → grant=0, no resp_valid; after release, core 0 wins when cores 0 and 3 request together.
